// File: rtl/system_alarm_pkg.sv
// Shared types and constants for the alarm sequencer behind the system interval timer.
package system_alarm_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_t;

  localparam logic [ADDR_W-1:0] ALM_ADDR_STATUS     = 3'd0;
  localparam logic [ADDR_W-1:0] ALM_ADDR_CONTROL    = 3'd1;
  localparam logic [ADDR_W-1:0] ALM_ADDR_TARGET     = 3'd2;
  localparam logic [ADDR_W-1:0] ALM_ADDR_COUNT      = 3'd3;
  localparam logic [ADDR_W-1:0] ALM_ADDR_SNOOZE_LEN = 3'd4;
  localparam logic [ADDR_W-1:0] ALM_ADDR_RING_LEN   = 3'd5;
  localparam logic [ADDR_W-1:0] ALM_ADDR_REMAIN     = 3'd6;

  localparam int unsigned STAT_RINGING_BIT  = 0;
  localparam int unsigned STAT_ARMED_BIT    = 1;
  localparam int unsigned STAT_SNOOZING_BIT = 2;
  localparam int unsigned STAT_EVENT_BIT    = 3;

  localparam int unsigned CTRL_ARM_EN_BIT = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned CTRL_SNOOZE_BIT = 2;
  localparam int unsigned CTRL_STOP_BIT   = 3;

  localparam logic [DATA_W-1:0] SNOOZE_LEN_RST = 16'd300;
  localparam logic [DATA_W-1:0] RING_LEN_RST   = 16'd0;

endpackage

// File: rtl/system_alarm_tone_gen.sv
// Buzzer square-wave generator: toggles every BUZZ_DIV clocks while enabled, held low otherwise.
module system_alarm_tone_gen #(
  parameter int unsigned BUZZ_DIV = 25000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tone
);

  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      div_cnt <= '0;
      tone    <= 1'b0;
    end else if (div_cnt == CNT_W'(BUZZ_DIV - 1)) begin
      div_cnt <= '0;
      tone    <= ~tone;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/system_alarm_ctrl.sv
// Alarm sequencer: counts timer ticks, rings on a target match, drives buzzer and irq.
// Optional snooze support is compiled in with ALARM_SNOOZE_EN.
module system_alarm_ctrl
  import system_alarm_pkg::*;
#(
  parameter int unsigned BUZZ_DIV = 25000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_in,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              irq,
  output logic              buzzer_out
);

  alarm_state_t      state;
  logic              tick_in_q, tick_q;
  logic              arm_en, irq_en, alarm_event;
  logic [DATA_W-1:0] target, count, ring_len, remain;
`ifdef ALARM_SNOOZE_EN
  logic [DATA_W-1:0] snooze_len;
`endif

  logic wr_c, wr_status_c, wr_ctrl_c, wr_target_c, wr_count_c, wr_ring_c;
  logic stop_c, snooze_c, match_c, ring_timeout_c, ring_exit_c, tone_en_c;
  logic [DATA_W-1:0] rd_mux_c;

  assign wr_c        = chipselect && !write_n;
  assign wr_status_c = wr_c && (address == ALM_ADDR_STATUS);
  assign wr_ctrl_c   = wr_c && (address == ALM_ADDR_CONTROL);
  assign wr_target_c = wr_c && (address == ALM_ADDR_TARGET);
  assign wr_count_c  = wr_c && (address == ALM_ADDR_COUNT);
  assign wr_ring_c   = wr_c && (address == ALM_ADDR_RING_LEN);
  assign stop_c      = wr_ctrl_c && writedata[CTRL_STOP_BIT];
`ifdef ALARM_SNOOZE_EN
  assign snooze_c    = wr_ctrl_c && writedata[CTRL_SNOOZE_BIT];
`else
  assign snooze_c    = 1'b0;
`endif

  // A software COUNT write in the same cycle suppresses the match.
  assign match_c        = tick_q && !wr_count_c && (DATA_W'(count + DATA_W'(1)) == target);
  assign ring_timeout_c = tick_q && (ring_len != '0) && (remain <= DATA_W'(1));
  assign ring_exit_c    = (state == RINGING) && (stop_c || snooze_c || ring_timeout_c);
  // Dropping enable on the exit cycle forces the buzzer low on the leaving edge.
  assign tone_en_c      = (state == RINGING) && !ring_exit_c;

  always_comb begin
    rd_mux_c = '0;
    unique case (address)
      ALM_ADDR_STATUS: begin
        rd_mux_c[STAT_RINGING_BIT]  = (state == RINGING);
        rd_mux_c[STAT_ARMED_BIT]    = (state == ARMED);
`ifdef ALARM_SNOOZE_EN
        rd_mux_c[STAT_SNOOZING_BIT] = (state == SNOOZE);
`endif
        rd_mux_c[STAT_EVENT_BIT]    = alarm_event;
      end
      ALM_ADDR_CONTROL: begin
        rd_mux_c[CTRL_ARM_EN_BIT] = arm_en;
        rd_mux_c[CTRL_IRQ_EN_BIT] = irq_en;
      end
      ALM_ADDR_TARGET:     rd_mux_c = target;
      ALM_ADDR_COUNT:      rd_mux_c = count;
`ifdef ALARM_SNOOZE_EN
      ALM_ADDR_SNOOZE_LEN: rd_mux_c = snooze_len;
`endif
      ALM_ADDR_RING_LEN:   rd_mux_c = ring_len;
      ALM_ADDR_REMAIN:     rd_mux_c = remain;
      default:             rd_mux_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tick_in_q   <= 1'b0;
      tick_q      <= 1'b0;
      arm_en      <= 1'b0;
      irq_en      <= 1'b0;
      alarm_event <= 1'b0;
      target      <= '0;
      count       <= '0;
      ring_len    <= RING_LEN_RST;
      remain      <= '0;
`ifdef ALARM_SNOOZE_EN
      snooze_len  <= SNOOZE_LEN_RST;
`endif
      readdata    <= '0;
      irq         <= 1'b0;
    end else begin
      // Edge detect is registered, so the FSM reacts two edges after tick_in rises.
      tick_in_q <= tick_in;
      tick_q    <= tick_in & ~tick_in_q;
      readdata  <= rd_mux_c;
      irq       <= alarm_event & irq_en;

      if (wr_count_c)  count <= writedata;
      else if (tick_q) count <= count + DATA_W'(1);
      if (wr_target_c) target   <= writedata;
      if (wr_ring_c)   ring_len <= writedata;
`ifdef ALARM_SNOOZE_EN
      if (wr_c && (address == ALM_ADDR_SNOOZE_LEN)) snooze_len <= writedata;
`endif
      if (wr_ctrl_c) begin
        arm_en <= writedata[CTRL_ARM_EN_BIT];
        irq_en <= writedata[CTRL_IRQ_EN_BIT];
      end
      if (wr_status_c) alarm_event <= 1'b0;

      // Event sets below are ordered after the STATUS clear so a coincident set wins.
      unique case (state)
        IDLE: if (arm_en) state <= ARMED;
        ARMED: begin
          if (!arm_en) begin
            state <= IDLE;
          end else if (match_c) begin
            state       <= RINGING;
            alarm_event <= 1'b1;
            remain      <= ring_len;
          end
        end
        RINGING: begin
          if (stop_c) begin
            state  <= IDLE;
            arm_en <= 1'b0;
`ifdef ALARM_SNOOZE_EN
          end else if (snooze_c) begin
            state  <= SNOOZE;
            remain <= snooze_len;
`endif
          end else if (ring_timeout_c) begin
            state  <= IDLE;
            remain <= '0;
          end else if (tick_q && (ring_len != '0)) begin
            remain <= remain - DATA_W'(1);
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (stop_c) begin
            state  <= IDLE;
            arm_en <= 1'b0;
          end else if (tick_q) begin
            if (remain <= DATA_W'(1)) begin
              state       <= RINGING;
              alarm_event <= 1'b1;
              remain      <= ring_len;
            end else begin
              remain <= remain - DATA_W'(1);
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  system_alarm_tone_gen #(
    .BUZZ_DIV (BUZZ_DIV)
  ) u_tone_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (tone_en_c),
    .tone   (buzzer_out)
  );

endmodule

// File: tb/tb_system_alarm_ctrl.sv
// Self-checking bench for system_alarm_ctrl: directed plan items plus a random phase against a register-level model.
module tb_system_alarm_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick_in = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = 16'd0;
  logic [15:0] readdata;
  logic        irq;
  logic        buzzer_out;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  system_alarm_ctrl #(.BUZZ_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_in    (tick_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .buzzer_out (buzzer_out)
  );

  // Behavioural model: alarm state plus the software-visible registers.
  localparam int S_IDLE = 0, S_ARMED = 1, S_RING = 2, S_SNZ = 3;
  int          m_state;
  logic        m_arm, m_irqen, m_ev;
  logic [15:0] m_target, m_count, m_snz, m_ring, m_remain;

  function automatic void model_reset();
    m_state = S_IDLE; m_arm = 1'b0; m_irqen = 1'b0; m_ev = 1'b0;
    m_target = 16'd0; m_count = 16'd0; m_snz = 16'd300; m_ring = 16'd0; m_remain = 16'd0;
  endfunction

  function automatic void model_settle();
    if (m_state == S_IDLE && m_arm) m_state = S_ARMED;
    else if (m_state == S_ARMED && !m_arm) m_state = S_IDLE;
  endfunction

  function automatic void model_tick();
    m_count = m_count + 16'd1;
    case (m_state)
      S_ARMED: if (m_count == m_target) begin
        m_state = S_RING; m_ev = 1'b1; m_remain = m_ring;
      end
      S_RING: if (m_ring != 16'd0) begin
        if (m_remain != 16'd0) m_remain = m_remain - 16'd1;
        if (m_remain == 16'd0) m_state = S_IDLE;
      end
      S_SNZ: begin
        if (m_remain != 16'd0) m_remain = m_remain - 16'd1;
        if (m_remain == 16'd0) begin
          m_state = S_RING; m_ev = 1'b1; m_remain = m_ring;
        end
      end
      default: ;
    endcase
    model_settle();
  endfunction

  function automatic void model_write(input logic [2:0] a, input logic [15:0] d);
    case (a)
      3'd0: m_ev = 1'b0;
      3'd1: begin
        m_arm = d[0]; m_irqen = d[1];
        if (d[3] && (m_state == S_RING || m_state == S_SNZ)) begin
          m_state = S_IDLE; m_arm = 1'b0;
        end
`ifdef ALARM_SNOOZE_EN
        else if (d[2] && m_state == S_RING) begin
          m_state = S_SNZ; m_remain = m_snz;
        end
`endif
      end
      3'd2: m_target = d;
      3'd3: m_count = d;
      3'd4: m_snz = d;
      3'd5: m_ring = d;
      default: ;
    endcase
    model_settle();
  endfunction

  function automatic logic [15:0] model_reg(input logic [2:0] a);
    logic [15:0] v;
    v = 16'd0;
    case (a)
      3'd0: v = {12'd0, m_ev, m_state == S_SNZ, m_state == S_ARMED, m_state == S_RING};
      3'd1: v = {14'd0, m_irqen, m_arm};
      3'd2: v = m_target;
      3'd3: v = m_count;
`ifdef ALARM_SNOOZE_EN
      3'd4: v = m_snz;
`endif
      3'd5: v = m_ring;
      3'd6: v = m_remain;
      default: v = 16'd0;
    endcase
    return v;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    repeat (2) @(negedge clk);
    model_write(a, d);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    d = readdata; chipselect = 1'b0;
  endtask

  task automatic do_tick();
    @(negedge clk); tick_in = 1'b1;
    @(negedge clk); tick_in = 1'b0;
    repeat (3) @(negedge clk);
    model_tick();
  endtask

  task automatic check_reg(input logic [2:0] a);
    logic [15:0] d;
    bus_read(a, d);
    check($sformatf("reg%0d", a), d, model_reg(a));
  endtask

  task automatic expect_reg(input string tag, input logic [2:0] a, input logic [15:0] v);
    logic [15:0] d;
    bus_read(a, d);
    check(tag, d, v);
  endtask

  task automatic check_all();
    for (int a = 0; a < 8; a++) check_reg(3'(a));
    check("irq", 16'(irq), 16'(m_ev && m_irqen));
  endtask

  initial begin
    logic [15:0] d;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_readdata", readdata, 16'd0);
    check("rst_irq", 16'(irq), 16'd0);
    check("rst_buzzer", 16'(buzzer_out), 16'd0);
    check_all();

    // Arm and match with exact irq/buzzer timing on the matching tick.
    bus_write(3'd2, 16'd5);
    bus_write(3'd3, 16'd0);
    bus_write(3'd1, 16'h0003);
    repeat (4) do_tick();
    expect_reg("count4", 3'd3, 16'd4);
    expect_reg("armed", 3'd0, 16'h0002);
    @(negedge clk); tick_in = 1'b1;
    @(negedge clk); tick_in = 1'b0;
    check("irq_before_ring", 16'(irq), 16'd0);
    @(negedge clk);
    check("irq_ring_edge", 16'(irq), 16'd0);
    check("buzz_ring_entry", 16'(buzzer_out), 16'd0);
    @(negedge clk);
    check("irq_next_cycle", 16'(irq), 16'd1);
    repeat (2) @(negedge clk);
    check("buzz_pre_toggle", 16'(buzzer_out), 16'd0);
    @(negedge clk);
    check("buzz_toggle1", 16'(buzzer_out), 16'd1);
    repeat (3) @(negedge clk);
    check("buzz_hold", 16'(buzzer_out), 16'd1);
    @(negedge clk);
    check("buzz_toggle2", 16'(buzzer_out), 16'd0);
    model_tick();
    expect_reg("status_ring", 3'd0, 16'h0009);
    check_all();

    // stop and snooze together: stop wins and clears arm_en.
    bus_write(3'd1, 16'h000E);
    expect_reg("stop_status", 3'd0, 16'h0008);
    expect_reg("stop_ctrl", 3'd1, 16'h0002);
    check("irq_held", 16'(irq), 16'd1);
    bus_write(3'd0, 16'hFFFF);
    check("irq_cleared", 16'(irq), 16'd0);

    // Ring timeout after RING_LEN ticks; event stays sticky.
    bus_write(3'd5, 16'd2);
    bus_write(3'd2, 16'h0011);
    bus_write(3'd3, 16'h0010);
    bus_write(3'd1, 16'h0003);
    do_tick();
    expect_reg("to_ring", 3'd0, 16'h0009);
    do_tick();
    expect_reg("to_remain", 3'd6, 16'd1);
    do_tick();
    expect_reg("to_done", 3'd0, 16'h000A);
    check("to_irq", 16'(irq), 16'd1);
    bus_write(3'd0, 16'd0);
    check("to_irq_clr", 16'(irq), 16'd0);
    check_all();

    // Count wrap into a target of zero.
    bus_write(3'd2, 16'h0000);
    bus_write(3'd3, 16'hFFFE);
    do_tick();
    expect_reg("wrap_armed", 3'd0, 16'h0002);
    do_tick();
    expect_reg("wrap_count", 3'd3, 16'h0000);
    expect_reg("wrap_ring", 3'd0, 16'h0009);

`ifdef ALARM_SNOOZE_EN
    bus_write(3'd4, 16'd3);
    bus_write(3'd1, 16'h0007);
    expect_reg("snz_status", 3'd0, 16'h000C);
    check("snz_buzz", 16'(buzzer_out), 16'd0);
    bus_write(3'd0, 16'd0);
    do_tick();
    do_tick();
    expect_reg("snz_wait", 3'd0, 16'h0004);
    do_tick();
    expect_reg("snz_rering", 3'd0, 16'h0009);
`else
    bus_write(3'd1, 16'h0007);
    expect_reg("snz_ignored", 3'd0, 16'h0009);
    expect_reg("snz_len_zero", 3'd4, 16'h0000);
`endif
    check_all();
    bus_write(3'd1, 16'h000A);
    bus_write(3'd0, 16'd0);

    // COUNT write coinciding with a tick: write wins, no match evaluated.
    bus_write(3'd1, 16'h0001);
    bus_write(3'd2, 16'h1234);
    bus_write(3'd3, 16'h1233);
    @(negedge clk); tick_in = 1'b1;
    @(negedge clk); tick_in = 1'b0;
    address = 3'd3; writedata = 16'h1234; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk); chipselect = 1'b0; write_n = 1'b1;
    repeat (3) @(negedge clk);
    m_count = 16'h1234;
    expect_reg("coll_count", 3'd3, 16'h1234);
    expect_reg("coll_nomatch", 3'd0, 16'h0002);

    // Random operations against the model.
    bus_write(3'd5, 16'd3);
    for (int i = 0; i < 300; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      d = 16'd0;
      case (op)
        0, 1, 2, 3: do_tick();
        4: begin
          d[0] = 1'($urandom_range(0, 3) != 0);
          d[1] = 1'($urandom_range(0, 1));
          d[2] = 1'($urandom_range(0, 2) == 0);
          d[3] = 1'($urandom_range(0, 4) == 0);
          bus_write(3'd1, d);
        end
        5: bus_write(3'd2, m_count + 16'($urandom_range(1, 3)));
        6: bus_write(3'd3, m_target - 16'($urandom_range(1, 3)));
        7: bus_write(3'd5, 16'($urandom_range(0, 3)));
        8: bus_write(3'd4, 16'($urandom_range(0, 3)));
        default: bus_write(3'd0, 16'($urandom));
      endcase
      check("rnd_irq", 16'(irq), 16'(m_ev && m_irqen));
      if (m_state != S_RING) check("rnd_buzz", 16'(buzzer_out), 16'd0);
      check_reg(3'($urandom_range(0, 7)));
    end
    check_all();

    // Reset while ringing with buzzer high.
    bus_write(3'd1, 16'h000A);
    bus_write(3'd0, 16'd0);
    bus_write(3'd5, 16'd0);
    bus_write(3'd2, 16'h0021);
    bus_write(3'd3, 16'h0020);
    bus_write(3'd1, 16'h0003);
    do_tick();
    repeat (2) @(negedge clk);
    check("pre_rst_buzz", 16'(buzzer_out), 16'd1);
    expect_reg("pre_rst_status", 3'd0, 16'h0009);
    check("pre_rst_irq", 16'(irq), 16'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_buzz", 16'(buzzer_out), 16'd0);
    check("mid_rst_irq", 16'(irq), 16'd0);
    check("mid_rst_rdata", readdata, 16'd0);
    reset = 1'b0;
    model_reset();
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/system_alarm_ctrl.md
# system_alarm_ctrl

Alarm sequencer downstream of the interval timer in the `system` Qsys design. It consumes the timer's periodic timeout (`irq`) as a tick, keeps a 16-bit tick count, and rings when the count matches a programmed target. While ringing it drives a square-wave buzzer output and an interrupt. Software controls it over a 16-bit Avalon-MM slave in the same register style as the timer.

## Interface
- `BUZZ_DIV`, 16'd25000: clocks per buzzer half-period; legal range 1..65535.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `tick_in`  in  1  timer timeout level; rising edge = one tick.
- `address`  in  3  register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  16  write data.
- `readdata`  out  16  registered read data; reset 0.
- `irq`  out  1  `alarm_event & irq_en`; reset 0.
- `buzzer_out`  out  1  square wave while RINGING, else 0; reset 0.

## Operation
- Write strobe: `chipselect && !write_n`. Reads have no side effects.
- Register map:
  - addr 0 STATUS. Bits: [0] ringing, [1] armed, [2] snoozing, [3] alarm_event (sticky). A write of any value clears alarm_event.
  - addr 1 CONTROL. Bits: [0] arm_en, [1] irq_en, [2] snooze (write-1 pulse, reads 0), [3] stop (write-1 pulse, reads 0).
  - addr 2 TARGET. Reset 0.
  - addr 3 COUNT. Read/write; reset 0.
  - addr 4 SNOOZE_LEN. Reset 300.
  - addr 5 RING_LEN. Reset 0; 0 = unlimited.
  - addr 6 REMAIN. Read-only snooze/ring down-counter.
  - addr 7 reads 0.
- Tick detection: `tick = tick_in & ~tick_in_q`.
- COUNT increments on every tick in every state and wraps 0xFFFF→0x0000.
- FSM states: IDLE, ARMED, RINGING, SNOOZE. Reset state is IDLE.
  - IDLE → ARMED when arm_en = 1.
  - ARMED → IDLE when arm_en = 0.
  - ARMED → RINGING on a tick where COUNT+1 == TARGET. That cycle sets alarm_event and loads REMAIN = RING_LEN.
  - RINGING → IDLE on stop. Stop also clears arm_en.
  - RINGING → SNOOZE on snooze. That cycle loads REMAIN = SNOOZE_LEN.
  - RINGING → IDLE when RING_LEN ≠ 0 and REMAIN reaches 0; REMAIN decrements on ticks. alarm_event stays set.
  - SNOOZE: REMAIN decrements on ticks. REMAIN == 0 → RINGING, setting alarm_event and reloading REMAIN = RING_LEN.
  - SNOOZE → IDLE on stop, which also clears arm_en.
- SNOOZE_LEN = 0: the next tick returns the FSM to RINGING.
- Simultaneous events:
  - stop and snooze in the same write: stop wins.
  - software COUNT write and tick in the same cycle: the write wins and no match is evaluated.
  - STATUS write and a new alarm_event set in the same cycle: set wins.
  - a TARGET write takes effect from the next cycle.
- `reset` mid-ring: FSM to IDLE, all registers to reset values, `buzzer_out` 0 next cycle.

## Timing
- `readdata` is valid on the cycle after address presentation (1-cycle latency), with no wait states.
- Tick edge to state change: 2 cycles. One cycle to register `tick_in_q`; the FSM updates on the next edge.
- `irq` is registered: asserts 1 cycle after alarm_event sets and deasserts 1 cycle after a STATUS write.
- `buzzer_out` starts at 0 on RINGING entry. It toggles every BUZZ_DIV clocks and forces to 0 on the same edge the FSM leaves RINGING.

## Configuration
- `ALARM_SNOOZE_EN` defined: full behaviour as above.
- `ALARM_SNOOZE_EN` undefined:
  - SNOOZE state, SNOOZE_LEN register and snooze bit are not compiled.
  - A snooze write is ignored.
  - addr 4 reads 0; STATUS[2] reads 0.
  - REMAIN tracks only the ring down-counter.

## Structure
- Package `system_alarm_pkg` holds:
  - state enum `alarm_state_t` (IDLE, ARMED, RINGING, SNOOZE);
  - register address constants `ALM_ADDR_*`;
  - CONTROL/STATUS bit-index constants;
  - reset constants for SNOOZE_LEN and RING_LEN.
- One sub-module, `system_alarm_tone_gen`:
  - inputs `clk`, `reset`, `enable`;
  - parameter BUZZ_DIV;
  - output `tone`;
  - contains the divide counter, which clears whenever `enable` is 0.

## Test plan
- Arm and match: TARGET=5, COUNT=0, arm_en=1, 5 ticks → RINGING on the 5th tick, STATUS=0x9, and with irq_en=1 `irq`=1 one cycle later.
- Wrap: COUNT=0xFFFE, TARGET=0x0000, 2 ticks → COUNT=0 and RINGING entered on the second tick.
- Snooze: while RINGING, SNOOZE_LEN=3 and write CONTROL snooze → SNOOZE and `buzzer_out`=0; after 3 ticks → RINGING again with alarm_event re-set.
- Ring timeout: RING_LEN=2 → IDLE after 2 ticks of ringing; STATUS[3] still 1; a STATUS write clears `irq`.
- Collision: in one write, CONTROL = stop|snooze → IDLE and arm_en=0. A COUNT write coinciding with a tick leaves COUNT = the written value.
- Buzzer and reset: BUZZ_DIV=4 while RINGING → `buzzer_out` toggles every 4 clocks; asserting `reset` mid-ring → all outputs 0 on the next edge.
